// File: rtl/gpio_bus_pkg.sv
// Shared types and field positions for the GPIO bus master.
// Imported by the interface, the phase timer and the master top.
package gpio_bus_pkg;

    localparam int PIN_W       = 3;
    localparam int CFG_W       = 3;
    localparam int PIN_LSB     = 0;
    localparam int CFG_LSB     = 3;
    localparam int VAL_BIT     = 6;
    localparam int ECHO_W      = CFG_LSB + CFG_W;
    localparam int GPIO_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2,
        ST_RSP  = 2'd3
    } mst_state_e;

    // True when the pin/cfg echo in a read word disagrees with the request.
    function automatic logic echo_bad(
        input logic [ECHO_W-1:0] echo,
        input logic [PIN_W-1:0]  pin,
        input logic [CFG_W-1:0]  cfg
    );
        return (echo[PIN_LSB +: PIN_W] != pin) ||
               (echo[CFG_LSB +: CFG_W] != cfg);
    endfunction

endpackage

// File: rtl/gpio_bus_master_if.sv
// Command/response handshake bundle between the APB-side command
// path (master) and the GPIO bus master (slave).
interface gpio_bus_master_if;
    import gpio_bus_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [PIN_W-1:0] cmd_pin;
    logic [CFG_W-1:0] cmd_cfg;
    logic             cmd_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_rdata;
    logic             rsp_error;

    modport master (
        output cmd_valid, cmd_write, cmd_pin, cmd_cfg, cmd_wdata,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_pin, cmd_cfg, cmd_wdata,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/gpio_phase_timer.sv
// Saturating wait-phase counter shared by the REQ and REL phases.
// term is high once the count sits at TIMEOUT_CYC-1.
module gpio_phase_timer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    assign term = (cnt_q == LAST);

    // Clear wins over count; stop at LAST instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !term) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_bus_master.sv
// Strobe/done initiator for the GPIO controller: one pin-config
// access at a time, with release phase and per-phase timeout.
module gpio_bus_master
    import gpio_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    gpio_bus_master_if.slave       cmd_if,
    output logic                   write,
    output logic                   read,
    output logic [PIN_W-1:0]       add_pin_number,
    output logic [CFG_W-1:0]       add_config,
    output logic                   data_in,
    input  logic [GPIO_WORD_W-1:0] data_out,
    input  logic                   write_done,
    input  logic                   read_done
);

    mst_state_e       state_q, state_d;
    logic             write_q, write_d;
    logic             read_q, read_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             wdata_q, wdata_d;
    logic             is_wr_q, is_wr_d;
    logic             rdata_q, rdata_d;
    logic             error_q, error_d;
    logic             valid_q, valid_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_term;
    logic sel_done;
    logic cmd_ready_w;
    logic unused_hi;

    // Value bit and echo fields are the only part of the word used.
    assign unused_hi = ^data_out[GPIO_WORD_W-1:VAL_BIT+1];

    // A stale done from a previous access blocks new commands.
    assign cmd_ready_w = (state_q == ST_IDLE) && !rst &&
                         !write_done && !read_done;
    assign sel_done    = is_wr_q ? write_done : read_done;

    assign cmd_if.cmd_ready = cmd_ready_w;
    assign cmd_if.rsp_valid = valid_q;
    assign cmd_if.rsp_rdata = rdata_q;
    assign cmd_if.rsp_error = error_q;
    assign write            = write_q;
    assign read             = read_q;
    assign add_pin_number   = pin_q;
    assign add_config       = cfg_q;
    assign data_in          = wdata_q;

    gpio_phase_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .term (tmr_term)
    );

    // Next-state and output logic for the access sequence.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        read_d  = read_q;
        pin_d   = pin_q;
        cfg_d   = cfg_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        error_d = error_q;
        valid_d = valid_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid && cmd_ready_w) begin
                    pin_d   = cmd_if.cmd_pin;
                    cfg_d   = cmd_if.cmd_cfg;
                    wdata_d = cmd_if.cmd_wdata;
                    is_wr_d = cmd_if.cmd_write;
                    write_d = cmd_if.cmd_write;
                    read_d  = !cmd_if.cmd_write;
                    rdata_d = 1'b0;
                    error_d = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                tmr_en = 1'b1;
                if (sel_done) begin
                    write_d = 1'b0;
                    read_d  = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = ST_REL;
                    if (!is_wr_q) begin
                        rdata_d = data_out[VAL_BIT];
                        error_d = echo_bad(data_out[ECHO_W-1:0],
                                           pin_q, cfg_q);
                    end
                end else if (tmr_term) begin
                    write_d = 1'b0;
                    read_d  = 1'b0;
                    error_d = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                tmr_en = 1'b1;
                if (!write_done && !read_done) begin
                    tmr_clr = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_RSP;
                end else if (tmr_term) begin
                    error_d = 1'b1;
                    tmr_clr = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (cmd_if.rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, strobe, address and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            pin_q   <= '0;
            cfg_q   <= '0;
            wdata_q <= 1'b0;
            is_wr_q <= 1'b0;
            rdata_q <= 1'b0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            read_q  <= read_d;
            pin_q   <= pin_d;
            cfg_q   <= cfg_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master: behavioural GPIO responder with fault
// modes, reference expectations queued at accept, monitor checks.
module tb_gpio_bus_master;

    localparam int TO = 16;
    localparam int HOLD = 20;

    typedef enum int {
        M_NORMAL, M_NODONE, M_STUCK, M_CORRUPT, M_WRONG
    } mode_e;

    typedef struct {
        logic rdata;
        logic error;
        int   lat;
        int   acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write, read;
    logic [2:0]  add_pin_number, add_config;
    logic        data_in;
    logic [31:0] data_out;
    logic        write_done, read_done;

    gpio_bus_master_if bus();

    gpio_bus_master #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_if         (bus),
        .write          (write),
        .read           (read),
        .add_pin_number (add_pin_number),
        .add_config     (add_config),
        .data_in        (data_in),
        .data_out       (data_out),
        .write_done     (write_done),
        .read_done      (read_done)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    n_wr = 0, n_rd = 0;
    int    wr_pulses = 0, rd_pulses = 0;
    int    stall_cfg = 0;
    mode_e mode = M_NORMAL;
    exp_t  exp_q[$];
    logic  gmem [8][8];
    logic  ref_mem [8][8];
    int    ext_w = 0, ext_r = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, want);
        end
    endtask

    // GPIO controller model: done follows strobe by one cycle.
    always @(posedge clk) begin
        logic ok, want_wd, want_rd;
        ok = (mode == M_NORMAL) || (mode == M_CORRUPT) ||
             (mode == M_STUCK);
        want_wd = (write && ok) || (read && mode == M_WRONG);
        want_rd = (read && ok) || (write && mode == M_WRONG);
        if (rst) begin
            write_done <= 1'b0;
            read_done  <= 1'b0;
            data_out   <= '0;
            ext_w      <= 0;
            ext_r      <= 0;
        end else begin
            if (want_wd) begin
                write_done <= 1'b1;
                ext_w <= (mode == M_STUCK) ? HOLD : 0;
            end else if (ext_w > 0) begin
                ext_w <= ext_w - 1;
            end else begin
                write_done <= 1'b0;
            end
            if (want_rd) begin
                read_done <= 1'b1;
                ext_r <= (mode == M_STUCK) ? HOLD : 0;
            end else if (ext_r > 0) begin
                ext_r <= ext_r - 1;
            end else begin
                read_done <= 1'b0;
            end
            if (write && ok)
                gmem[add_pin_number][add_config] <= data_in;
            if (read && ok)
                data_out <= {25'($urandom),
                             gmem[add_pin_number][add_config],
                             add_config,
                             add_pin_number ^
                             ((mode == M_CORRUPT) ? 3'b110 : 3'b000)};
        end
    end

    // Expected response from the access rules for the current mode.
    function automatic exp_t predict(input logic w, input logic [2:0] p,
                                     input logic [2:0] c, input logic d);
        exp_t e;
        logic ok;
        ok = (mode == M_NORMAL) || (mode == M_CORRUPT) ||
             (mode == M_STUCK);
        e.error = !ok || (mode == M_STUCK) ||
                  (mode == M_CORRUPT && !w);
        e.rdata = (!w && ok) ? ref_mem[p][c] : 1'b0;
        case (mode)
            M_NODONE: e.lat = TO + 1;
            M_STUCK:  e.lat = 2 + TO;
            M_WRONG:  e.lat = TO + 2;
            default:  e.lat = 4;
        endcase
        if (w && ok) ref_mem[p][c] = d;
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic w, input logic [2:0] p,
                        input logic [2:0] c, input logic d);
        bit   got = 0;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_pin   = p;
        bus.cmd_cfg   = c;
        bus.cmd_wdata = d;
        for (int i = 0; i < 300 && !got; i++) begin
            #1;
            if (bus.cmd_ready) begin
                e = predict(w, p, c, d);
                e.acc = cyc + 1;
                exp_q.push_back(e);
                if (w) n_wr++;
                else n_rd++;
                got = 1;
                @(posedge clk);
                #1 bus.cmd_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int i = 0;
        @(negedge clk);
        #1;
        while ((exp_q.size() != 0 || bus.rsp_valid) && i < 400) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (i >= 400) chk("drain_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_write"}, int'(write), 0);
        chk({nm, "_read"}, int'(read), 0);
        chk({nm, "_pin"}, int'(add_pin_number), 0);
        chk({nm, "_cfg"}, int'(add_config), 0);
        chk({nm, "_din"}, int'(data_in), 0);
        chk({nm, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({nm, "_rsp_rdata"}, int'(bus.rsp_rdata), 0);
        chk({nm, "_rsp_error"}, int'(bus.rsp_error), 0);
        chk({nm, "_cmd_ready"}, int'(bus.cmd_ready), 0);
    endtask

    task automatic pulse_rst(input string nm);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs(nm);
        rst = 1'b0;
    endtask

    // Response monitor: pops the oldest expectation on each new response.
    initial begin
        exp_t cur;
        bit   have = 0;
        int   stall = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                        cur.rdata = bus.rsp_rdata;
                        cur.error = bus.rsp_error;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_rdata", int'(bus.rsp_rdata),
                            int'(cur.rdata));
                        chk("rsp_error", int'(bus.rsp_error),
                            int'(cur.error));
                        chk("rsp_latency", cyc - cur.acc, cur.lat);
                    end
                    have = 1;
                    stall = stall_cfg;
                end else begin
                    chk("hold_rdata", int'(bus.rsp_rdata),
                        int'(cur.rdata));
                    chk("hold_error", int'(bus.rsp_error),
                        int'(cur.error));
                end
                if (stall == 0) begin
                    bus.rsp_ready = 1'b1;
                    have = 0;
                end else begin
                    stall--;
                    bus.rsp_ready = 1'b0;
                end
            end else begin
                have = 0;
                bus.rsp_ready = 1'b0;
            end
        end
    end

    // Protocol watch: strobe exclusivity, blocked ready, pulse counts.
    initial begin
        logic pw = 1'b0, pr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (write_done || read_done))
                chk("ready_while_done", int'(bus.cmd_ready), 0);
            if (write || read)
                chk("one_strobe", int'(write && read), 0);
            if (write && !pw) wr_pulses++;
            if (read && !pr) rd_pulses++;
            pw = write;
            pr = read;
        end
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_pin   = '0;
        bus.cmd_cfg   = '0;
        bus.cmd_wdata = 1'b0;
        for (int p = 0; p < 8; p++)
            for (int c = 0; c < 8; c++) begin
                gmem[p][c]    = 1'b0;
                ref_mem[p][c] = 1'b0;
            end

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        mode = M_NORMAL;
        send(1'b1, 3'd5, 3'd1, 1'b1);
        drain();
        send(1'b0, 3'd5, 3'd1, 1'b0);
        drain();

        mode = M_NODONE;
        send(1'b1, 3'd2, 3'd3, 1'b1);
        drain();
        chk("abort_strobe_low", int'(write), 0);

        mode = M_STUCK;
        send(1'b1, 3'd6, 3'd0, 1'b1);
        drain();

        mode = M_CORRUPT;
        send(1'b1, 3'd4, 3'd2, 1'b1);
        drain();
        send(1'b0, 3'd4, 3'd2, 1'b0);
        drain();

        mode = M_WRONG;
        send(1'b1, 3'd1, 3'd1, 1'b1);
        drain();
        send(1'b0, 3'd6, 3'd0, 1'b0);
        drain();

        mode = M_NODONE;
        send(1'b1, 3'd3, 3'd3, 1'b1);
        repeat (5) @(negedge clk);
        pulse_rst("rst_in_req");
        repeat (3) @(negedge clk);
        chk("no_rsp_after_req_rst", int'(bus.rsp_valid), 0);

        mode = M_NORMAL;
        stall_cfg = 1000;
        send(1'b0, 3'd5, 3'd1, 1'b0);
        for (int i = 0; i < 50 && !bus.rsp_valid; i++)
            @(negedge clk);
        chk("rsp_before_rst", int'(bus.rsp_valid), 1);
        pulse_rst("rst_in_rsp");
        stall_cfg = 0;
        repeat (3) @(negedge clk);
        chk("no_rsp_after_rsp_rst", int'(bus.rsp_valid), 0);

        stall_cfg = 3;
        send(1'b1, 3'd7, 3'd7, 1'b1);
        drain();
        send(1'b0, 3'd7, 3'd7, 1'b0);
        drain();

        for (int n = 0; n < 80; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5) mode = M_NORMAL;
            else if (r == 6) mode = M_NODONE;
            else if (r == 7) mode = M_STUCK;
            else if (r == 8) mode = M_CORRUPT;
            else mode = M_WRONG;
            stall_cfg = int'($urandom_range(0, 3));
            send(1'(($urandom) & 1), 3'($urandom), 3'($urandom),
                 1'(($urandom) & 1));
            drain();
        end

        mode = M_NORMAL;
        repeat (30) @(negedge clk);
        chk("wr_pulses", wr_pulses, n_wr);
        chk("rd_pulses", rd_pulses, n_rd);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
